// File: rtl/temp_sensor_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : temp_sensor_reg_bank
// Description : Temperature sensor register bank with debounced hi/lo alarms.
//               Optional MAX_TEMP tracking via TEMP_SENSOR_MAX_TRACK_EN.
// Revision    : 1.0
// ============================================================================
module temp_sensor_reg_bank #(
    parameter int DATA_W   = 16,
    parameter int DEBOUNCE = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic [2:0]        address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              alarm_irq
);

    localparam logic [2:0]        c_addr_ctrl    = 3'd0;
    localparam logic [2:0]        c_addr_temp    = 3'd1;
    localparam logic [2:0]        c_addr_hi_thr  = 3'd2;
    localparam logic [2:0]        c_addr_lo_thr  = 3'd3;
    localparam logic [2:0]        c_addr_status  = 3'd4;
    localparam logic [2:0]        c_addr_cnt     = 3'd5;
    localparam logic [2:0]        c_addr_max     = 3'd6;
    localparam logic [2:0]        c_addr_scratch = 3'd7;
    localparam logic [3:0]        c_debounce     = 4'(DEBOUNCE);
    localparam logic [DATA_W-1:0] c_hi_thr_rst   = {1'b0, {(DATA_W-1){1'b1}}};

    logic              r_enable;
    logic              r_irq_en;
    logic [DATA_W-1:0] r_temp;
    logic [DATA_W-1:0] r_hi_thr;
    logic [DATA_W-1:0] r_lo_thr;
    logic [2:0]        r_status;
    logic [DATA_W-1:0] r_sample_cnt;
    logic [DATA_W-1:0] r_scratch;
    logic [3:0]        r_hi_cnt;
    logic [3:0]        r_lo_cnt;
    logic              r_prev_accept;

    logic              w_accept;
    logic              w_above;
    logic              w_below;
    logic [3:0]        w_hi_cnt_nxt;
    logic [3:0]        w_lo_cnt_nxt;
    logic [2:0]        w_status_set;
    logic [2:0]        w_status_clr;
    logic [DATA_W-1:0] w_max_rd;
    logic [DATA_W-1:0] w_rd_data;

    assign w_accept = sample_valid & r_enable;
    assign w_above  = $signed(sample_data) > $signed(r_hi_thr);
    assign w_below  = $signed(sample_data) < $signed(r_lo_thr);

    // Counters saturate at DEBOUNCE; in-range samples restart the count.
    always_comb begin
        w_hi_cnt_nxt = r_hi_cnt;
        w_lo_cnt_nxt = r_lo_cnt;
        if (!r_enable) begin
            w_hi_cnt_nxt = '0;
            w_lo_cnt_nxt = '0;
        end else if (w_accept) begin
            if (w_above)
                w_hi_cnt_nxt = (r_hi_cnt == c_debounce) ? r_hi_cnt : r_hi_cnt + 4'd1;
            else
                w_hi_cnt_nxt = '0;
            if (w_below)
                w_lo_cnt_nxt = (r_lo_cnt == c_debounce) ? r_lo_cnt : r_lo_cnt + 4'd1;
            else
                w_lo_cnt_nxt = '0;
        end
    end

    always_comb begin
        w_status_set    = '0;
        w_status_set[0] = w_accept & w_above & (w_hi_cnt_nxt == c_debounce);
        w_status_set[1] = w_accept & w_below & (w_lo_cnt_nxt == c_debounce);
        w_status_set[2] = w_accept & r_prev_accept;
        w_status_clr    = (write && address == c_addr_status) ? data_in[2:0] : 3'b000;
    end

`ifdef TEMP_SENSOR_MAX_TRACK_EN
    localparam logic [DATA_W-1:0] c_most_neg = {1'b1, {(DATA_W-1){1'b0}}};
    logic [DATA_W-1:0] r_max_temp;
    logic [DATA_W-1:0] w_max_base;

    // A write re-arms tracking; a sample in the same cycle competes with the re-armed value.
    assign w_max_base = (write && address == c_addr_max) ? c_most_neg : r_max_temp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_max_temp <= '0;
        else if (w_accept && ($signed(sample_data) > $signed(w_max_base)))
            r_max_temp <= sample_data;
        else
            r_max_temp <= w_max_base;
    end

    assign w_max_rd = r_max_temp;
`else
    assign w_max_rd = '0;
`endif

    always_comb begin
        w_rd_data = '0;
        case (address)
            c_addr_ctrl:    w_rd_data = {{(DATA_W-2){1'b0}}, r_irq_en, r_enable};
            c_addr_temp:    w_rd_data = r_temp;
            c_addr_hi_thr:  w_rd_data = r_hi_thr;
            c_addr_lo_thr:  w_rd_data = r_lo_thr;
            c_addr_status:  w_rd_data = {{(DATA_W-3){1'b0}}, r_status};
            c_addr_cnt:     w_rd_data = r_sample_cnt;
            c_addr_max:     w_rd_data = w_max_rd;
            c_addr_scratch: w_rd_data = r_scratch;
            default:        w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable      <= 1'b0;
            r_irq_en      <= 1'b0;
            r_temp        <= '0;
            r_hi_thr      <= c_hi_thr_rst;
            r_lo_thr      <= '0;
            r_status      <= '0;
            r_sample_cnt  <= '0;
            r_scratch     <= '0;
            r_hi_cnt      <= '0;
            r_lo_cnt      <= '0;
            r_prev_accept <= 1'b0;
            data_out      <= '0;
            rd_valid      <= 1'b0;
        end else begin
            if (write) begin
                case (address)
                    c_addr_ctrl: begin
                        r_enable <= data_in[0];
                        r_irq_en <= data_in[1];
                    end
                    c_addr_hi_thr:  r_hi_thr  <= data_in;
                    c_addr_lo_thr:  r_lo_thr  <= data_in;
                    c_addr_scratch: r_scratch <= data_in;
                    default: ;
                endcase
            end
            if (w_accept) begin
                r_temp       <= sample_data;
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
            r_status      <= (r_status & ~w_status_clr) | w_status_set;
            r_hi_cnt      <= w_hi_cnt_nxt;
            r_lo_cnt      <= w_lo_cnt_nxt;
            r_prev_accept <= w_accept;
            if (read)
                data_out <= w_rd_data;
            rd_valid <= read;
        end
    end

    assign alarm_irq = r_irq_en & (|r_status);

endmodule
`default_nettype wire
